prog_mem_loader: RTL

PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

---
 rtl/prog_mem_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/prog_mem_loader.sv
// Byte-stream program loader: assembles MSB-first bytes into words, writes them to an
// on-chip program memory and serves 1-cycle registered fetches. Optional: PROG_MEM_BYPASS_EN.
module prog_mem_loader #(
    parameter int                ADDR_W    = 11,
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] HALT_WORD = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              load_busy,
    output logic              load_done,
    output logic [ADDR_W:0]   load_words,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid
);

    localparam int BYTES = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic [ADDR_W-1:0] wr_addr_reg;
    logic [ADDR_W:0]   load_words_reg;
    logic [DATA_W-1:0] fetch_data_reg;
    logic              fetch_valid_reg;

    logic [DATA_W-1:0] new_word;
    logic [DATA_W-1:0] rd_word;
    logic              word_done;
    logic              restart;
    logic              shift_en;
    logic              wr_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // load_start always wins over a coincident byte, so the byte is dropped.
    always_comb begin
        state_next = state_reg;
        restart    = 1'b0;
        shift_en   = 1'b0;
        wr_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load_start) begin
                    state_next = LOAD;
                    restart    = 1'b1;
                end
            end
            LOAD: begin
                if (load_start) begin
                    restart = 1'b1;
                end else if (byte_valid) begin
                    shift_en = 1'b1;
                    if (word_done) begin
                        wr_en = 1'b1;
                        if ((new_word == HALT_WORD) || (wr_addr_reg == {ADDR_W{1'b1}})) begin
                            state_next = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (load_start) begin
                    state_next = LOAD;
                    restart    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Byte assembly; a single-byte word needs no partial register or counter.
    generate
        if (BYTES == 1) begin : gen_single_byte
            assign new_word  = byte_in;
            assign word_done = 1'b1;
        end else begin : gen_multi_byte
            localparam int BCNT_W = $clog2(BYTES);
            localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES - 1);

            logic [DATA_W-9:0] part_reg;
            logic [BCNT_W-1:0] byte_cnt_reg;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    part_reg     <= '0;
                    byte_cnt_reg <= '0;
                end else if (restart) begin
                    part_reg     <= '0;
                    byte_cnt_reg <= '0;
                end else if (shift_en) begin
                    part_reg     <= new_word[DATA_W-9:0];
                    byte_cnt_reg <= word_done ? '0 : byte_cnt_reg + 1'b1;
                end
            end

            assign new_word  = {part_reg, byte_in};
            assign word_done = (byte_cnt_reg == LAST_BYTE);
        end
    endgenerate

    // The address is never used after the last-address write (state leaves LOAD).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr_reg    <= '0;
            load_words_reg <= '0;
        end else if (restart) begin
            wr_addr_reg    <= '0;
            load_words_reg <= '0;
        end else if (wr_en) begin
            wr_addr_reg    <= wr_addr_reg + 1'b1;
            load_words_reg <= load_words_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr_reg] <= new_word;
        end
    end

`ifdef PROG_MEM_BYPASS_EN
    assign rd_word = (wr_en && (wr_addr_reg == fetch_addr)) ? new_word : mem[fetch_addr];
`else
    assign rd_word = mem[fetch_addr];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_data_reg  <= '0;
            fetch_valid_reg <= 1'b0;
        end else begin
            fetch_valid_reg <= fetch_en;
            if (fetch_en) begin
                fetch_data_reg <= rd_word;
            end
        end
    end

    assign load_busy   = (state_reg == LOAD);
    assign load_done   = (state_reg == DONE);
    assign load_words  = load_words_reg;
    assign fetch_data  = fetch_data_reg;
    assign fetch_valid = fetch_valid_reg;

endmodule
